csr_mtrap: RTL and testbench

CSR_MTRAP -- requirements
Module: csr_mtrap

---
 rtl/csr_pkg.sv | 43 ++++
 rtl/csr_counter.sv | 36 +++
 rtl/csr_mtrap.sv | 274 +++++++++++++++++++++++++++
 tb/tb_csr_mtrap.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/csr_pkg.sv
// ---------------------------------------------------------------------------
// csr_pkg -- shared constants for the machine-mode trap CSR block.
//
// Contents:
//   * CSR address constants (mstatus .. mhartid)
//   * CSR instruction function encodings (none / RW / RS / RC)
//   * bit positions inside mstatus and mip/mie
// ---------------------------------------------------------------------------
package csr_pkg;

   // CSR addresses
   localparam logic [11:0] CSR_MSTATUS  = 12'h300;
   localparam logic [11:0] CSR_MIE      = 12'h304;
   localparam logic [11:0] CSR_MTVEC    = 12'h305;
   localparam logic [11:0] CSR_MSCRATCH = 12'h340;
   localparam logic [11:0] CSR_MEPC     = 12'h341;
   localparam logic [11:0] CSR_MCAUSE   = 12'h342;
   localparam logic [11:0] CSR_MTVAL    = 12'h343;
   localparam logic [11:0] CSR_MIP      = 12'h344;
   localparam logic [11:0] CSR_MCYCLE   = 12'hB00;
   localparam logic [11:0] CSR_MINSTRET = 12'hB02;
   localparam logic [11:0] CSR_MHARTID  = 12'hF14;

   // CSR instruction function
   typedef enum logic [1:0] {
      FUNCT_NONE = 2'b00,
      FUNCT_RW   = 2'b01,
      FUNCT_RS   = 2'b10,
      FUNCT_RC   = 2'b11
   } csr_funct_e;

   // mstatus fields
   localparam int MSTATUS_MIE    = 3;
   localparam int MSTATUS_MPIE   = 7;
   localparam int MSTATUS_MPP_LO = 11;
   localparam int MSTATUS_MPP_HI = 12;

   // mip / mie interrupt bits
   localparam int MIP_MSIP = 3;
   localparam int MIP_MTIP = 7;
   localparam int MIP_MEIP = 11;

endpackage

// File: rtl/csr_counter.sv
// ---------------------------------------------------------------------------
// csr_counter -- XLEN-wide free-running counter with a software write port.
//
// Ports:
//   clk, rst      clock, synchronous active-high reset (clears count)
//   inc           advance the count by one this cycle
//   wr_en,wr_data load wr_data; takes priority over inc in the same cycle
//   count         current counter value
// The count wraps from all-ones to zero.
// ---------------------------------------------------------------------------
module csr_counter #(
   parameter int XLEN = 64
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            inc,
   input  logic            wr_en,
   input  logic [XLEN-1:0] wr_data,
   output logic [XLEN-1:0] count
);

   logic [XLEN-1:0] count_reg;

   always_ff @(posedge clk) begin
      if (rst) begin
         count_reg <= '0;
      end else if (wr_en) begin
         count_reg <= wr_data;
      end else if (inc) begin
         count_reg <= count_reg + XLEN'(1);
      end
   end

   assign count = count_reg;

endmodule

// File: rtl/csr_mtrap.sv
// ---------------------------------------------------------------------------
// csr_mtrap -- machine-mode CSR file with trap entry / mret handling.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   csr_req/csr_addr/csr_funct    CSR instruction (funct 01=RW 10=RS 11=RC)
//   csr_wdata                     CSR operand
//   csr_rdata                     pre-write CSR value, registered
//   csr_illegal                   one-cycle pulse on an illegal access
//   trap_req/trap_cause/trap_pc/trap_tval   trap entry
//   mret                          return from trap
//   instret                       instruction retired this cycle
//   irq_ext/irq_timer/irq_sw      level interrupt sources
//   irq_pending                   enabled interrupt present
//   redirect_valid/redirect_pc    one-cycle PC redirect after trap / mret
//
// Configuration macro: CSR_MTRAP_COUNTERS_EN
//   defined   -> mcycle / minstret are live counters
//   undefined -> 0xB00 / 0xB02 read zero, writes are silently dropped
// ---------------------------------------------------------------------------
module csr_mtrap
   import csr_pkg::*;
#(
   parameter int              XLEN        = 64,
   parameter logic [XLEN-1:0] MTVEC_RESET = '0
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            csr_req,
   input  logic [11:0]     csr_addr,
   input  logic [1:0]      csr_funct,
   input  logic [XLEN-1:0] csr_wdata,
   output logic [XLEN-1:0] csr_rdata,
   output logic            csr_illegal,
   input  logic            trap_req,
   input  logic [XLEN-1:0] trap_cause,
   input  logic [XLEN-1:0] trap_pc,
   input  logic [XLEN-1:0] trap_tval,
   input  logic            mret,
   input  logic            instret,
   input  logic            irq_ext,
   input  logic            irq_timer,
   input  logic            irq_sw,
   output logic            irq_pending,
   output logic            redirect_valid,
   output logic [XLEN-1:0] redirect_pc
);

   // Only the three machine interrupt bits of mie are implemented.
   localparam logic [XLEN-1:0] IRQ_MASK =
      XLEN'((1 << MIP_MEIP) | (1 << MIP_MTIP) | (1 << MIP_MSIP));

   // mip bit positions in the same order as the irq_in vector below.
   localparam int MIP_POS [3] = '{MIP_MSIP, MIP_MTIP, MIP_MEIP};

   csr_funct_e funct;
   assign funct = csr_funct_e'(csr_funct);

   // ------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------
   logic            mie_bit_reg;
   logic            mpie_bit_reg;
   logic [XLEN-1:0] mie_reg;
   logic [XLEN-1:0] mtvec_reg;
   logic [XLEN-1:0] mscratch_reg;
   logic [XLEN-1:0] mepc_reg;
   logic [XLEN-1:0] mcause_reg;
   logic [XLEN-1:0] mtval_reg;
   logic [2:0]      mip_bit_reg;

   logic [XLEN-1:0] csr_rdata_reg;
   logic            csr_illegal_reg;
   logic            redirect_valid_reg;
   logic [XLEN-1:0] redirect_pc_reg;

   logic [XLEN-1:0] mcycle_value;
   logic [XLEN-1:0] minstret_value;

   // ------------------------------------------------------------------
   // Interrupt sampling: one register per source
   // ------------------------------------------------------------------
   logic [2:0] irq_in;
   assign irq_in = {irq_ext, irq_timer, irq_sw};

   generate
      for (genvar gi = 0; gi < 3; gi++) begin : g_mip
         always_ff @(posedge clk) begin
            if (rst) begin
               mip_bit_reg[gi] <= 1'b0;
            end else begin
               mip_bit_reg[gi] <= irq_in[gi];
            end
         end
      end
   endgenerate

   // ------------------------------------------------------------------
   // Architectural views of the packed registers
   // ------------------------------------------------------------------
   logic [XLEN-1:0] mstatus_value;
   logic [XLEN-1:0] mip_value;

   always_comb begin
      mstatus_value = '0;
      mstatus_value[MSTATUS_MIE]  = mie_bit_reg;
      mstatus_value[MSTATUS_MPIE] = mpie_bit_reg;
      mstatus_value[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
   end

   always_comb begin
      mip_value = '0;
      for (int i = 0; i < 3; i++) begin
         mip_value[MIP_POS[i]] = mip_bit_reg[i];
      end
   end

   assign irq_pending = mie_bit_reg & (|(mip_value & mie_reg));

   // ------------------------------------------------------------------
   // CSR read / modify
   // ------------------------------------------------------------------
   logic [XLEN-1:0] old_value;
   logic [XLEN-1:0] new_value;
   logic            addr_mapped;
   logic            csr_legal;
   logic            csr_op;
   logic            csr_wr;

   always_comb begin
      old_value   = '0;
      addr_mapped = 1'b1;
      case (csr_addr)
         CSR_MSTATUS:  old_value = mstatus_value;
         CSR_MIE:      old_value = mie_reg;
         CSR_MTVEC:    old_value = mtvec_reg;
         CSR_MSCRATCH: old_value = mscratch_reg;
         CSR_MEPC:     old_value = mepc_reg;
         CSR_MCAUSE:   old_value = mcause_reg;
         CSR_MTVAL:    old_value = mtval_reg;
         CSR_MIP:      old_value = mip_value;
         CSR_MCYCLE:   old_value = mcycle_value;
         CSR_MINSTRET: old_value = minstret_value;
         CSR_MHARTID:  old_value = '0;
         default:      addr_mapped = 1'b0;
      endcase
   end

   always_comb begin
      case (funct)
         FUNCT_RW: new_value = csr_wdata;
         FUNCT_RS: new_value = old_value | csr_wdata;
         FUNCT_RC: new_value = old_value & ~csr_wdata;
         default:  new_value = old_value;
      endcase
   end

   // mhartid is read-only: any write attempt faults.
   assign csr_legal = addr_mapped &
                      ~((csr_addr == CSR_MHARTID) && (funct != FUNCT_NONE));
   // A trap or mret in the same cycle drops the CSR instruction entirely.
   assign csr_op    = csr_req & ~trap_req & ~mret;
   assign csr_wr    = csr_op & csr_legal & (funct != FUNCT_NONE);

   // ------------------------------------------------------------------
   // Trap target: direct, or vectored for interrupts (cause MSB set)
   // ------------------------------------------------------------------
   logic [XLEN-1:0] trap_base;
   logic [XLEN-1:0] trap_offset;
   logic [XLEN-1:0] trap_target;

   assign trap_base   = {mtvec_reg[XLEN-1:2], 2'b00};
   assign trap_offset = {1'b0, trap_cause[XLEN-2:0]} << 2;
   assign trap_target = ((mtvec_reg[1:0] == 2'b01) && trap_cause[XLEN-1])
                        ? trap_base + trap_offset : trap_base;

   // ------------------------------------------------------------------
   // CSR state update
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         mie_bit_reg  <= 1'b0;
         mpie_bit_reg <= 1'b0;
         mie_reg      <= '0;
         mtvec_reg    <= MTVEC_RESET;
         mscratch_reg <= '0;
         mepc_reg     <= '0;
         mcause_reg   <= '0;
         mtval_reg    <= '0;
      end else if (trap_req) begin
         mepc_reg     <= trap_pc & ~XLEN'(3);
         mcause_reg   <= trap_cause;
         mtval_reg    <= trap_tval;
         mpie_bit_reg <= mie_bit_reg;
         mie_bit_reg  <= 1'b0;
      end else if (mret) begin
         mie_bit_reg  <= mpie_bit_reg;
         mpie_bit_reg <= 1'b1;
      end else if (csr_wr) begin
         case (csr_addr)
            CSR_MSTATUS: begin
               mie_bit_reg  <= new_value[MSTATUS_MIE];
               mpie_bit_reg <= new_value[MSTATUS_MPIE];
            end
            CSR_MIE:      mie_reg      <= new_value & IRQ_MASK;
            CSR_MTVEC:    mtvec_reg    <= new_value;
            CSR_MSCRATCH: mscratch_reg <= new_value;
            CSR_MEPC:     mepc_reg     <= new_value & ~XLEN'(3);
            CSR_MCAUSE:   mcause_reg   <= new_value;
            CSR_MTVAL:    mtval_reg    <= new_value;
            default: ;  // mip, counters (own module), mhartid: nothing here
         endcase
      end
   end

   // ------------------------------------------------------------------
   // Registered outputs
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         csr_rdata_reg      <= '0;
         csr_illegal_reg    <= 1'b0;
         redirect_valid_reg <= 1'b0;
         redirect_pc_reg    <= '0;
      end else begin
         // rdata holds its last value when no CSR instruction executes
         if (csr_op) begin
            csr_rdata_reg <= csr_legal ? old_value : '0;
         end
         csr_illegal_reg    <= csr_op & ~csr_legal;
         redirect_valid_reg <= trap_req | mret;
         if (trap_req) begin
            redirect_pc_reg <= trap_target;
         end else if (mret) begin
            redirect_pc_reg <= mepc_reg;
         end
      end
   end

   assign csr_rdata      = csr_rdata_reg;
   assign csr_illegal    = csr_illegal_reg;
   assign redirect_valid = redirect_valid_reg;
   assign redirect_pc    = redirect_pc_reg;

   // ------------------------------------------------------------------
   // Performance counters
   // ------------------------------------------------------------------
`ifdef CSR_MTRAP_COUNTERS_EN
   csr_counter #(.XLEN(XLEN)) u_mcycle (
      .clk     (clk),
      .rst     (rst),
      .inc     (1'b1),
      .wr_en   (csr_wr && (csr_addr == CSR_MCYCLE)),
      .wr_data (new_value),
      .count   (mcycle_value)
   );

   csr_counter #(.XLEN(XLEN)) u_minstret (
      .clk     (clk),
      .rst     (rst),
      .inc     (instret),
      .wr_en   (csr_wr && (csr_addr == CSR_MINSTRET)),
      .wr_data (new_value),
      .count   (minstret_value)
   );
`else
   assign mcycle_value   = '0;
   assign minstret_value = '0;

   logic unused_instret;
   assign unused_instret = instret;
`endif

endmodule

// File: tb/tb_csr_mtrap.sv
// ---------------------------------------------------------------------------
// tb_csr_mtrap -- self-checking bench for csr_mtrap (XLEN=64,
// MTVEC_RESET=0x100). A table of CSR accesses is applied first, followed by
// hand-written trap / mret / interrupt / counter / reset sequences.
// Counter expectations follow CSR_MTRAP_COUNTERS_EN.
// ---------------------------------------------------------------------------
module tb_csr_mtrap;

   localparam int XLEN = 64;
   localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic            csr_req = 1'b0;
   logic [11:0]     csr_addr = '0;
   logic [1:0]      csr_funct = '0;
   logic [XLEN-1:0] csr_wdata = '0;
   logic [XLEN-1:0] csr_rdata;
   logic            csr_illegal;
   logic            trap_req = 1'b0;
   logic [XLEN-1:0] trap_cause = '0;
   logic [XLEN-1:0] trap_pc = '0;
   logic [XLEN-1:0] trap_tval = '0;
   logic            mret = 1'b0;
   logic            instret = 1'b0;
   logic            irq_ext = 1'b0;
   logic            irq_timer = 1'b0;
   logic            irq_sw = 1'b0;
   logic            irq_pending;
   logic            redirect_valid;
   logic [XLEN-1:0] redirect_pc;

   int total = 0;
   int bad   = 0;

   csr_mtrap #(.XLEN(XLEN), .MTVEC_RESET(64'h100)) dut (
      .clk            (clk),
      .rst            (rst),
      .csr_req        (csr_req),
      .csr_addr       (csr_addr),
      .csr_funct      (csr_funct),
      .csr_wdata      (csr_wdata),
      .csr_rdata      (csr_rdata),
      .csr_illegal    (csr_illegal),
      .trap_req       (trap_req),
      .trap_cause     (trap_cause),
      .trap_pc        (trap_pc),
      .trap_tval      (trap_tval),
      .mret           (mret),
      .instret        (instret),
      .irq_ext        (irq_ext),
      .irq_timer      (irq_timer),
      .irq_sw         (irq_sw),
      .irq_pending    (irq_pending),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [11:0] addr;
      logic [1:0]  funct;
      logic [63:0] wdata;
      logic [63:0] exp_rdata;
      logic        exp_ill;
   } vec_t;

   vec_t vecs [21];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end else begin
         $display("ok   %s: 0x%0h", name, act);
      end
   endtask

   // one clock edge, outputs sampled 1 time unit later
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic csr_op(input logic [11:0] a, input logic [1:0] f, input logic [63:0] w);
      csr_req   = 1'b1;
      csr_addr  = a;
      csr_funct = f;
      csr_wdata = w;
      step();
      csr_req   = 1'b0;
   endtask

   task automatic csr_read_check(input string name, input logic [11:0] a, input logic [63:0] exp);
      csr_op(a, 2'b00, 64'h0);
      check(name, csr_rdata, exp);
   endtask

   initial begin
      // addr, funct, wdata, expected rdata, expected illegal
      vecs[0]  = '{12'h340, 2'b01, 64'hA5,   64'h0,    1'b0};
      vecs[1]  = '{12'h340, 2'b10, 64'h5A,   64'hA5,   1'b0};
      vecs[2]  = '{12'h340, 2'b11, 64'h0F,   64'hFF,   1'b0};
      vecs[3]  = '{12'h340, 2'b00, 64'h0,    64'hF0,   1'b0};
      vecs[4]  = '{12'h7C0, 2'b01, 64'h1,    64'h0,    1'b1};
      vecs[5]  = '{12'hF14, 2'b01, 64'h1234, 64'h0,    1'b1};
      vecs[6]  = '{12'hF14, 2'b00, 64'h0,    64'h0,    1'b0};
      vecs[7]  = '{12'h304, 2'b01, ONES,     64'h0,    1'b0};
      vecs[8]  = '{12'h304, 2'b00, 64'h0,    64'h888,  1'b0};
      vecs[9]  = '{12'h344, 2'b01, ONES,     64'h0,    1'b0};
      vecs[10] = '{12'h344, 2'b00, 64'h0,    64'h0,    1'b0};
      vecs[11] = '{12'h300, 2'b01, ONES,     64'h1800, 1'b0};
      vecs[12] = '{12'h300, 2'b00, 64'h0,    64'h1888, 1'b0};
      vecs[13] = '{12'h300, 2'b01, 64'h0,    64'h1888, 1'b0};
      vecs[14] = '{12'h341, 2'b01, 64'h1237, 64'h0,    1'b0};
      vecs[15] = '{12'h341, 2'b00, 64'h0,    64'h1234, 1'b0};
      vecs[16] = '{12'h305, 2'b01, 64'h1001, 64'h100,  1'b0};
      vecs[17] = '{12'h305, 2'b00, 64'h0,    64'h1001, 1'b0};
      vecs[18] = '{12'h342, 2'b01, 64'hABC,  64'h0,    1'b0};
      vecs[19] = '{12'h342, 2'b11, ONES,     64'hABC,  1'b0};
      vecs[20] = '{12'h342, 2'b00, 64'h0,    64'h0,    1'b0};

      // reset
      step();
      step();
      rst = 1'b0;
      check("reset rdata", csr_rdata, 64'h0);
      check("reset illegal", {63'h0, csr_illegal}, 64'h0);
      check("reset redirect_valid", {63'h0, redirect_valid}, 64'h0);
      check("reset redirect_pc", redirect_pc, 64'h0);
      check("reset irq_pending", {63'h0, irq_pending}, 64'h0);

      // table-driven CSR accesses
      for (int i = 0; i < 21; i++) begin
         csr_op(vecs[i].addr, vecs[i].funct, vecs[i].wdata);
         check($sformatf("vec%0d addr=%0h rdata", i, vecs[i].addr), csr_rdata, vecs[i].exp_rdata);
         check($sformatf("vec%0d addr=%0h illegal", i, vecs[i].addr), {63'h0, csr_illegal},
               {63'h0, vecs[i].exp_ill});
      end

      // enable MIE (mstatus currently 0x1800)
      csr_op(12'h300, 2'b01, 64'h8);
      check("mstatus set MIE rdata", csr_rdata, 64'h1800);

      // trap + mret + csr write in the same cycle: only trap takes effect
      trap_req   = 1'b1;
      mret       = 1'b1;
      trap_cause = 64'h8000_0000_0000_0007;
      trap_pc    = 64'h2002;
      trap_tval  = 64'h55;
      csr_req    = 1'b1;
      csr_addr   = 12'h340;
      csr_funct  = 2'b01;
      csr_wdata  = 64'h77;
      step();
      trap_req = 1'b0;
      mret     = 1'b0;
      csr_req  = 1'b0;
      check("trap redirect_valid", {63'h0, redirect_valid}, 64'h1);
      check("trap redirect_pc", redirect_pc, 64'h101C);
      check("trap rdata held", csr_rdata, 64'h1800);
      check("trap no illegal", {63'h0, csr_illegal}, 64'h0);
      step();
      check("trap redirect one cycle", {63'h0, redirect_valid}, 64'h0);
      csr_read_check("trap mepc", 12'h341, 64'h2000);
      csr_read_check("trap mcause", 12'h342, 64'h8000_0000_0000_0007);
      csr_read_check("trap mtval", 12'h343, 64'h55);
      csr_read_check("trap mstatus", 12'h300, 64'h1880);
      csr_read_check("trap mscratch kept", 12'h340, 64'hF0);

      // mret
      mret = 1'b1;
      step();
      mret = 1'b0;
      check("mret redirect_valid", {63'h0, redirect_valid}, 64'h1);
      check("mret redirect_pc", redirect_pc, 64'h2000);
      step();
      check("mret redirect one cycle", {63'h0, redirect_valid}, 64'h0);
      csr_read_check("mret mstatus", 12'h300, 64'h1888);

      // timer interrupt, mie=0x888, MIE=1
      irq_timer = 1'b1;
      #1;
      check("irq pending before sample", {63'h0, irq_pending}, 64'h0);
      step();
      check("irq pending after sample", {63'h0, irq_pending}, 64'h1);
      csr_read_check("mip timer", 12'h344, 64'h80);
      irq_timer = 1'b0;
      step();
      check("irq pending cleared", {63'h0, irq_pending}, 64'h0);

      // exception in vectored mode uses the base address
      trap_req   = 1'b1;
      trap_cause = 64'h2;
      trap_pc    = 64'h3000;
      trap_tval  = 64'h0;
      step();
      trap_req = 1'b0;
      check("exception redirect_pc", redirect_pc, 64'h1000);

      // counters
`ifdef CSR_MTRAP_COUNTERS_EN
      csr_op(12'hB00, 2'b01, ONES);
      check("mcycle write illegal", {63'h0, csr_illegal}, 64'h0);
      csr_read_check("mcycle all ones", 12'hB00, ONES);
      csr_read_check("mcycle wrapped", 12'hB00, 64'h0);
      instret = 1'b1;
      csr_op(12'hB02, 2'b01, 64'h5);
      instret = 1'b0;
      csr_read_check("minstret write wins", 12'hB02, 64'h5);
`else
      csr_op(12'hB00, 2'b01, 64'h7);
      check("mcycle write illegal", {63'h0, csr_illegal}, 64'h0);
      csr_read_check("mcycle reads 0", 12'hB00, 64'h0);
      instret = 1'b1;
      csr_op(12'hB02, 2'b01, 64'h5);
      instret = 1'b0;
      check("minstret write illegal", {63'h0, csr_illegal}, 64'h0);
      csr_read_check("minstret reads 0", 12'hB02, 64'h0);
`endif

      // reset wins over a simultaneous trap
      rst        = 1'b1;
      trap_req   = 1'b1;
      trap_cause = 64'h3;
      trap_pc    = 64'h4444;
      step();
      trap_req = 1'b0;
      rst      = 1'b0;
      check("reset beats trap redirect_valid", {63'h0, redirect_valid}, 64'h0);
      check("reset beats trap redirect_pc", redirect_pc, 64'h0);
      csr_read_check("reset mtvec", 12'h305, 64'h100);
      csr_read_check("reset mepc", 12'h341, 64'h0);
      csr_read_check("reset mstatus", 12'h300, 64'h1800);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
